// File: rtl/ifetch_axi_rd_arbiter.sv
// rtl/ifetch_axi_rd_arbiter.sv - one-outstanding AXI3 read arbiter for three instruction-fetch requesters
// Fixed priority 0>1>2 with forced grant of the prefetcher after STARVE_MAX lost arbitrations.
module ifetch_axi_rd_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [2:0]  req,
    input  logic [95:0] addr,
    input  logic [11:0] len,
    output logic [2:0]  gnt,
    output logic [2:0]  rvalid_o,
    output logic        rlast_o,
    output logic [31:0] rdata_o,
    output logic        err,
    output logic        busy,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    state_t             state_q, state_d;
    logic [1:0]         owner_q, owner_d;
    logic [31:0]        addr_q, addr_d;
    logic [3:0]         len_q, len_d;
    logic [CNT_W-1:0]   starve_q, starve_d;
    logic [3:0]         beat_q, beat_d;
    logic               err_seen_q, err_seen_d;
    logic [1:0]         win;
    logic               beat_bad;

    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign arid    = {2'b00, owner_q};
    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign busy    = (state_q != S_IDLE);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            owner_q    <= 2'd0;
            addr_q     <= 32'd0;
            len_q      <= 4'd0;
            starve_q   <= '0;
            beat_q     <= 4'd0;
            err_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            starve_q   <= starve_d;
            beat_q     <= beat_d;
            err_seen_q <= err_seen_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        len_d      = len_q;
        starve_d   = starve_q;
        beat_d     = beat_q;
        err_seen_d = err_seen_q;
        arvalid    = 1'b0;
        rready     = 1'b0;
        gnt        = 3'b000;
        rvalid_o   = 3'b000;
        rlast_o    = 1'b0;
        rdata_o    = 32'd0;
        err        = 1'b0;

        // Prefetcher promotion overrides fixed priority once it has lost enough times.
        if (req[2] && starve_q == STARVE_LIM) win = 2'd2;
        else if (req[0])                      win = 2'd0;
        else if (req[1])                      win = 2'd1;
        else                                  win = 2'd2;

        beat_bad = (rresp != 2'b00) || (rid != arid);

        case (state_q)
            S_IDLE: begin
                if (req != 3'b000) begin
                    owner_d = win;
                    case (win)
                        2'd0:    begin addr_d = addr[31:0];  len_d = len[3:0];  end
                        2'd1:    begin addr_d = addr[63:32]; len_d = len[7:4];  end
                        default: begin addr_d = addr[95:64]; len_d = len[11:8]; end
                    endcase
                    if (req[2] && win != 2'd2)
                        starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + CNT_W'(1);
                    else
                        starve_d = '0;
                    state_d = S_AR;
                end
            end
            S_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    gnt        = 3'b001 << owner_q;
                    beat_d     = 4'd0;
                    err_seen_d = 1'b0;
                    state_d    = S_R;
                end
            end
            S_R: begin
                rready   = 1'b1;
                rvalid_o = rvalid ? (3'b001 << owner_q) : 3'b000;
                rdata_o  = rdata;
                rlast_o  = rlast;
                if (rvalid) begin
                    if (rlast) begin
                        // Burst length is judged only at the beat the slave marks last.
                        err     = err_seen_q || beat_bad || (beat_q != len_q);
                        state_d = S_IDLE;
                    end else begin
                        err_seen_d = err_seen_q || beat_bad;
                        beat_d     = beat_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ifetch_axi_rd_arbiter.sv
// tb/tb_ifetch_axi_rd_arbiter.sv - randomized and directed self-checking bench for ifetch_axi_rd_arbiter
module tb_ifetch_axi_rd_arbiter;
    localparam int STARVE_MAX = 4;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [2:0]  req;
    logic [95:0] addr;
    logic [11:0] len;
    logic [2:0]  gnt, rvalid_o;
    logic        rlast_o, err, busy;
    logic [31:0] rdata_o;
    logic [3:0]  arid, arlen, arcache;
    logic [31:0] araddr;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    always #5 aclk = ~aclk;

    ifetch_axi_rd_arbiter #(.STARVE_MAX(STARVE_MAX), .CNT_W(3)) dut (
        .aclk(aclk), .aresetn(aresetn), .req(req), .addr(addr), .len(len),
        .gnt(gnt), .rvalid_o(rvalid_o), .rlast_o(rlast_o), .rdata_o(rdata_o),
        .err(err), .busy(busy), .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arlock(arlock), .arcache(arcache),
        .arprot(arprot), .arvalid(arvalid), .arready(arready), .rid(rid),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level reference: one burst record plus the prefetcher loss count.
    bit          m_act, m_ar_done, m_bad;
    int          m_owner, m_beats, m_starve, m_w;
    logic [31:0] m_addr;
    logic [3:0]  m_len;
    logic [2:0]  e_gnt, e_rv;
    logic        e_arv, e_rr, e_err, e_beat;

    task automatic model_reset();
        m_act = 0; m_ar_done = 0; m_bad = 0; m_owner = 0; m_beats = 0;
        m_starve = 0; m_addr = 32'd0; m_len = 4'd0;
    endtask

    always @(negedge aclk) begin
        if (!aresetn) model_reset();
        e_arv  = m_act && !m_ar_done;
        e_rr   = m_act && m_ar_done;
        e_gnt  = (e_arv && arready) ? 3'(1 << m_owner) : 3'b000;
        e_beat = e_rr && rvalid;
        e_rv   = e_beat ? 3'(1 << m_owner) : 3'b000;
        e_err  = e_beat && rlast &&
                 (m_bad || rresp != 2'b00 || int'(rid) != m_owner || m_beats != int'(m_len));
        chk("busy", busy, m_act);
        chk("arvalid", arvalid, e_arv);
        chk("araddr", araddr, m_addr);
        chk("arlen", arlen, m_len);
        chk("arid", arid, m_owner);
        chk("gnt", gnt, e_gnt);
        chk("rready", rready, e_rr);
        chk("rvalid_o", rvalid_o, e_rv);
        chk("err", err, e_err);
        chk("ar_const", {arsize, arburst, arlock, arcache, arprot}, 14'b010_01_00_0000_000);
        if (e_rv != 3'b000) begin
            chk("rdata_o", rdata_o, rdata);
            chk("rlast_o", rlast_o, rlast);
        end
        if (aresetn) begin
            if (!m_act) begin
                if (req != 3'b000) begin
                    if (req[2] && m_starve >= STARVE_MAX) m_w = 2;
                    else if (req[0])                      m_w = 0;
                    else if (req[1])                      m_w = 1;
                    else                                  m_w = 2;
                    if (req[2] && m_w != 2) m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
                    else                    m_starve = 0;
                    m_act = 1; m_ar_done = 0; m_owner = m_w;
                    m_addr = addr[m_w*32 +: 32];
                    m_len  = len[m_w*4 +: 4];
                end
            end else if (!m_ar_done) begin
                if (arready) begin m_ar_done = 1; m_beats = 0; m_bad = 0; end
            end else if (rvalid) begin
                if (rlast) m_act = 0;
                else begin
                    m_bad = m_bad || rresp != 2'b00 || int'(rid) != m_owner;
                    m_beats++;
                end
            end
        end
    end

    // Stimulus knobs, requester next-values and slave state
    logic        rst_n_n;
    logic [2:0]  req_n, drop_on_gnt;
    logic [95:0] addr_n;
    logic [11:0] len_n;
    bit          rand_req, rand_slave, rand_rst, prev_arv;
    int          ar_delay, early_last, bad_resp;
    bit          s_burst;
    int          s_len, s_beat, s_wait;
    logic [3:0]  s_id;
    logic [39:0] prev_ar;
    int          gnt_cnt[3], beat_o[3];
    int          err_cnt, first_arv_cyc, first_gnt_cyc, unstable;
    logic [31:0] first_arv_addr;
    int          gnt_q[$];

    task automatic clear_stats();
        for (int i = 0; i < 3; i++) begin gnt_cnt[i] = 0; beat_o[i] = 0; end
        err_cnt = 0; first_arv_cyc = -1; first_gnt_cyc = -1; unstable = 0;
        first_arv_addr = 32'd0;
        gnt_q.delete();
    endtask

    task automatic drive_slave();
        if (arvalid) arready = rand_slave ? ($urandom_range(0, 1) == 1) : (s_wait >= ar_delay);
        else         arready = rand_slave ? ($urandom_range(0, 1) == 1) : 1'b0;
        rdata = $urandom;
        if (s_burst) begin
            rvalid = rand_slave ? ($urandom_range(0, 9) < 7) : 1'b1;
            rlast  = (s_beat == s_len) || (s_beat == early_last);
            rresp  = (s_beat == bad_resp) ? 2'b10 : 2'b00;
            rid    = s_id;
            if (rand_slave) begin
                if ($urandom_range(0, 39) == 0) rlast = 1'b1;
                if ($urandom_range(0, 49) == 0) rresp = 2'($urandom_range(1, 3));
                if ($urandom_range(0, 49) == 0) rid = 4'($urandom_range(3, 15));
            end
        end else begin
            rvalid = rand_slave ? ($urandom_range(0, 1) == 1) : 1'b0;
            rlast  = ($urandom_range(0, 1) == 1);
            rresp  = 2'b00;
            rid    = 4'd0;
        end
    endtask

    task automatic monitor();
        if (!aresetn) begin s_burst = 0; s_wait = 0; prev_arv = 0; return; end
        if (rready && rvalid) begin
            if (rlast) s_burst = 0; else s_beat++;
        end
        if (arvalid && arready) begin
            s_burst = 1; s_len = int'(arlen); s_id = arid; s_beat = 0; s_wait = 0;
        end else if (arvalid) s_wait++;
        if (arvalid && first_arv_cyc < 0) begin first_arv_cyc = cyc; first_arv_addr = araddr; end
        if (arvalid && prev_arv && {araddr, arlen, arid} != prev_ar) unstable++;
        prev_arv = arvalid;
        prev_ar  = {araddr, arlen, arid};
        for (int i = 0; i < 3; i++) begin
            if (gnt[i]) begin
                gnt_cnt[i]++;
                gnt_q.push_back(i);
                if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
                if (drop_on_gnt[i] && (!rand_req || $urandom_range(0, 9) < 7)) req_n[i] = 1'b0;
            end
            if (rvalid_o[i]) beat_o[i]++;
        end
        if (err) err_cnt++;
    endtask

    task automatic tick();
        @(posedge aclk);
        cyc++;
        #2;
        if (rand_rst) rst_n_n = ($urandom_range(0, 399) != 0);
        if (rand_req) begin
            for (int i = 0; i < 3; i++) begin
                if (!req_n[i] && $urandom_range(0, 99) < 15) begin
                    req_n[i] = 1'b1;
                    addr_n[i*32 +: 32] = $urandom & 32'hffff_fffc;
                    len_n[i*4 +: 4]    = 4'($urandom_range(0, 7));
                end
            end
        end
        aresetn = rst_n_n;
        req = req_n; addr = addr_n; len = len_n;
        drive_slave();
        #6;
        monitor();
    endtask

    task automatic wait_done(input int limit, input string name);
        int n = 0;
        while ((req_n != 3'b000 || busy || arvalid) && n < limit) begin tick(); n++; end
        chk({name, "_done"}, (n < limit), 1'b1);
    endtask

    task automatic request(input int i, input logic [31:0] a, input logic [3:0] l);
        req_n[i] = 1'b1;
        addr_n[i*32 +: 32] = a;
        len_n[i*4 +: 4] = l;
    endtask

    initial begin
        int n, c0;
        bit pinned;
        rst_n_n = 0; aresetn = 0; req = 0; addr = 0; len = 0;
        req_n = 0; addr_n = 0; len_n = 0; drop_on_gnt = 3'b111;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        rand_req = 0; rand_slave = 0; rand_rst = 0;
        ar_delay = 0; early_last = -1; bad_resp = -1;
        s_burst = 0; s_len = 0; s_beat = 0; s_wait = 0; s_id = 0; prev_arv = 0; prev_ar = 0;
        clear_stats();
        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_araddr", araddr, 32'd0);
        rst_n_n = 1;
        repeat (2) tick();

        // Single refill burst, arready two cycles late
        clear_stats(); ar_delay = 2;
        request(0, 32'h1fc0_0040, 4'd15);
        tick(); c0 = cyc;
        wait_done(100, "t1");
        chk("t1_arv_latency", first_arv_cyc - c0, 1);
        chk("t1_araddr", first_arv_addr, 32'h1fc0_0040);
        chk("t1_gnt0", gnt_cnt[0], 1);
        chk("t1_beats0", beat_o[0], 16);
        chk("t1_err", err_cnt, 0);

        // Fixed priority with all three pending
        clear_stats(); ar_delay = 0;
        request(0, 32'h100, 4'd1); request(1, 32'h200, 4'd1); request(2, 32'h300, 4'd1);
        tick();
        wait_done(200, "t2");
        chk("t2_ngnt", gnt_q.size(), 3);
        if (gnt_q.size() == 3) begin
            chk("t2_first", gnt_q[0], 0);
            chk("t2_second", gnt_q[1], 1);
            chk("t2_third", gnt_q[2], 2);
        end

        // Starvation promotion of the prefetcher
        clear_stats(); drop_on_gnt = 3'b110; pinned = 0;
        request(0, 32'h400, 4'd0); request(2, 32'h800, 4'd0);
        n = 0;
        while (gnt_cnt[2] == 0 && n < 300) begin
            tick(); n++;
            if (gnt_cnt[0] == 4 && !pinned) begin chk("t3_model_starve4", m_starve, 4); pinned = 1; end
        end
        chk("t3_bound", (n < 300), 1'b1);
        req_n = 3'b000; drop_on_gnt = 3'b111;
        wait_done(100, "t3");
        chk("t3_req2_arb_index", gnt_q.size(), 5);
        if (gnt_q.size() == 5) chk("t3_last_owner", gnt_q[4], 2);
        chk("t3_model_starve0", m_starve, 0);

        // Early rlast, then bad rresp
        clear_stats(); early_last = 3;
        request(0, 32'hA00, 4'd15); tick();
        wait_done(100, "t4a");
        chk("t4a_err", err_cnt, 1);
        chk("t4a_beats", beat_o[0], 4);
        clear_stats(); early_last = -1; bad_resp = 5;
        request(1, 32'hB00, 4'd7); tick();
        wait_done(100, "t4b");
        chk("t4b_err", err_cnt, 1);
        chk("t4b_beats", beat_o[1], 8);
        chk("t4_busy", busy, 1'b0);
        bad_resp = -1;

        // Async reset during beat 7
        clear_stats();
        request(2, 32'hC00, 4'd15);
        n = 0;
        while (beat_o[2] < 7 && n < 200) begin tick(); n++; end
        chk("t5_bound", (n < 200), 1'b1);
        rst_n_n = 0; tick();
        chk("t5_arvalid", arvalid, 1'b0);
        chk("t5_rready", rready, 1'b0);
        chk("t5_rvalid_o", rvalid_o, 3'b000);
        rst_n_n = 1; tick();
        clear_stats(); repeat (4) tick();
        chk("t5_quiet", gnt_cnt[0] + gnt_cnt[1] + gnt_cnt[2] + beat_o[0] + beat_o[1] + beat_o[2], 0);
        request(1, 32'hD00, 4'd0); tick();
        wait_done(100, "t5");
        chk("t5_gnt1", gnt_cnt[1], 1);
        chk("t5_beats1", beat_o[1], 1);
        chk("t5_err", err_cnt, 0);

        // Long arready stall
        clear_stats(); ar_delay = 20;
        request(0, 32'hE00, 4'd3); tick();
        wait_done(100, "t6");
        chk("t6_stall", first_gnt_cyc - first_arv_cyc, 20);
        chk("t6_stable", unstable, 0);
        chk("t6_gnt_once", gnt_cnt[0], 1);

        // Randomized traffic with occasional resets
        clear_stats(); rand_req = 1; rand_slave = 1; rand_rst = 1;
        repeat (3000) tick();
        rand_req = 0; rand_rst = 0; rst_n_n = 1; req_n = 3'b000;
        n = 0;
        while ((busy || arvalid) && n < 500) begin tick(); n++; end
        chk("rand_drain", (n < 500), 1'b1);
        chk("rand_activity", (gnt_cnt[0] > 10 && gnt_cnt[1] > 10 && gnt_cnt[2] > 10), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
